// File: rtl/branch_pkg.sv
// Shared types for the branch resolve queue.
// Entry layout, FSM states and ISA constants.
package branch_pkg;

  localparam int BRQ_XLEN   = 32;
  localparam int BRQ_IDX_W  = 10;
  localparam int INSN_BYTES = 4;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } brq_state_e;

  typedef struct packed {
    logic [BRQ_XLEN-1:0]  pc;
    logic [BRQ_IDX_W-1:0] pred_idx;
    logic                 pred_taken;
    logic [BRQ_XLEN-1:0]  pred_target;
  } brq_entry_t;

endpackage

// File: rtl/brq_sat_counter.sv
// Saturating event counter.
// Sticks at all-ones instead of wrapping.
module brq_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);

  // count events, hold at the top value
  always_ff @(posedge clk) begin
    if (rst)
      value <= '0;
    else if (inc && value != '1)
      value <= value + W'(1);
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order in-flight branch queue feeding gshare training.
// Entry widths follow the branch_pkg constants.
module branch_resolve_queue
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = BRQ_IDX_W,
  parameter int XLEN  = BRQ_XLEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [XLEN-1:0]            enq_pc,
  input  logic [IDX_W-1:0]           enq_pred_idx,
  input  logic                       enq_pred_taken,
  input  logic [XLEN-1:0]            enq_pred_target,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic [XLEN-1:0]            res_target,
  input  logic                       flush,
  output logic                       upd_write,
  output logic                       upd_outcome,
  output logic [IDX_W-1:0]           upd_idx,
  output logic                       mispredict,
  output logic [XLEN-1:0]            redirect_pc,
  output logic                       res_err,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                br_cnt,
  output logic [31:0]                mp_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  brq_entry_t       q_mem [DEPTH];
  brq_entry_t       head_e;
  brq_entry_t       new_e;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  brq_state_e       state;

  logic            in_run;
  logic            res_acc;
  logic            res_bad;
  logic            enq_fire;
  logic            miss;
  logic            mp_fire;
  logic            clear;
  logic [XLEN-1:0] redir;

  assign head_e = q_mem[head];
  assign in_run = (state == RUN);

  assign enq_ready = in_run && (count != FULL) && !flush;
  assign enq_fire  = enq_valid && enq_ready;

  assign res_acc = res_valid && in_run && (count != '0);
  assign res_bad = res_valid && !res_acc;

  assign miss = (head_e.pred_taken != res_taken) ||
                (res_taken && head_e.pred_target != res_target);

  // an external flush wins over redirecting on a mispredict
  assign mp_fire = res_acc && miss && !flush;
  assign clear   = flush || mp_fire;

  assign redir = res_taken ? res_target
                           : head_e.pc + XLEN'(INSN_BYTES);

  assign new_e.pc          = enq_pc;
  assign new_e.pred_idx    = enq_pred_idx;
  assign new_e.pred_taken  = enq_pred_taken;
  assign new_e.pred_target = enq_pred_target;

  // write the tail slot; stale slots are ignored once pointers reset
  always_ff @(posedge clk) begin
    if (enq_fire)
      q_mem[tail] <= new_e;
  end

  // head/tail/count bookkeeping with single-cycle clear
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (res_acc)
        head <= head + PTR_W'(1);
      if (enq_fire)
        tail <= tail + PTR_W'(1);
      count <= count + CNT_W'(enq_fire)
                     - CNT_W'(res_acc);
    end
  end

  // RUN/RECOVER sequencing; RECOVER lasts one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      unique case (1'b1)
        flush:   state <= RUN;
        mp_fire: state <= RECOVER;
        default: state <= RUN;
      endcase
    end
  end

  // registered predictor update and redirect pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_write   <= 1'b0;
      upd_outcome <= 1'b0;
      upd_idx     <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      res_err     <= 1'b0;
    end else begin
      upd_write   <= res_acc;
      upd_outcome <= res_acc && res_taken;
      upd_idx     <= res_acc ? head_e.pred_idx : '0;
      mispredict  <= mp_fire;
      redirect_pc <= mp_fire ? redir : '0;
      res_err     <= res_bad;
    end
  end

  brq_sat_counter #(.W(32)) u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (res_acc),
    .value (br_cnt)
  );

  brq_sat_counter #(.W(32)) u_mp_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mp_fire),
    .value (mp_cnt)
  );

endmodule
